// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: decode-side read ports, writeback write port and
// bulk-clear request. The register file takes the slave side.
interface reg_file_mp_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = $clog2(NREG)
);
   logic [NRD-1:0]      rd_en_in;
   logic [NRD*AW-1:0]   rd_addr_in;
   logic [NRD*XLEN-1:0] rs_data_out;
   logic                wr_en_in;
   logic [AW-1:0]       wr_addr_in;
   logic [XLEN-1:0]     wr_data_in;
   logic                clr_req_in;
   logic                busy_out;

   modport master (
      output rd_en_in, rd_addr_in, wr_en_in, wr_addr_in, wr_data_in, clr_req_in,
      input  rs_data_out, busy_out
   );

   modport slave (
      input  rd_en_in, rd_addr_in, wr_en_in, wr_addr_in, wr_data_in, clr_req_in,
      output rs_data_out, busy_out
   );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with hardwired x0 and a sequenced bulk clear.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_mp #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG),
   parameter int NRD  = 2
) (
   input  logic         clk_in,
   input  logic         rst_in,
   reg_file_mp_if.slave bus
);

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] mem_q [1:NREG-1];
   logic [XLEN-1:0] mem_d [1:NREG-1];
   logic [XLEN-1:0] rs_q [NRD];
   logic [XLEN-1:0] rs_d [NRD];
   logic [AW-1:0]   rd_addr [NRD];
   logic            busy;
   logic            wr_ok;

   assign busy         = (state_q == CLEAR);
   assign wr_ok        = bus.wr_en_in && !busy && (bus.wr_addr_in != '0);
   assign bus.busy_out = busy;

   for (genvar k = 0; k < NRD; k++) begin : g_port
      assign rd_addr[k]                       = bus.rd_addr_in[k*AW +: AW];
      assign bus.rs_data_out[k*XLEN +: XLEN]  = rs_q[k];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.clr_req_in) begin
               state_d = CLEAR;
               cnt_d   = AW'(1);
            end
         end
         CLEAR: begin
            if (cnt_q == AW'(NREG-1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A write accepted alongside a clear request lands first; the sweep overwrites it later.
   always_comb begin
      mem_d = mem_q;
      if (wr_ok) begin
         mem_d[bus.wr_addr_in] = bus.wr_data_in;
      end
      if (busy) begin
         mem_d[cnt_q] = '0;
      end
   end

   always_comb begin
      rs_d = rs_q;
      for (int k = 0; k < NRD; k++) begin
         if (bus.rd_en_in[k]) begin
            if ((rd_addr[k] == '0) || busy) begin
               rs_d[k] = '0;
            end else if (BYPASS_EN && wr_ok && (bus.wr_addr_in == rd_addr[k])) begin
               rs_d[k] = bus.wr_data_in;
            end else begin
               rs_d[k] = mem_q[rd_addr[k]];
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         for (int i = 1; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
         for (int k = 0; k < NRD; k++) begin
            rs_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mem_q   <= mem_d;
         rs_q    <= rs_d;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a 32-entry/2-port instance against a reference
// model, plus a 16-entry/1-port instance for reset-abort and clear-length checks.
module tb_reg_file_mp;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic rst16_n;

   always #5 clk = ~clk;

   reg_file_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus32 ();
   reg_file_mp_if #(.XLEN(32), .NREG(16), .NRD(1)) bus16 ();

   reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2)) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus32)
   );

   reg_file_mp #(.XLEN(32), .NREG(16), .NRD(1)) dut16 (
      .clk_in (clk),
      .rst_in (rst16_n),
      .bus    (bus16)
   );

   typedef struct {
      string       tag;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mdl_mem [32];
   logic [31:0] mdl_rs [2];
   logic        mdl_busy;
   int          mdl_cnt;
   int          busy_seen;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic void modelReset();
      for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
      mdl_rs[0] = '0;
      mdl_rs[1] = '0;
      mdl_busy  = 1'b0;
      mdl_cnt   = 0;
   endfunction

   // One clock of the 32-entry DUT: drive, predict, push, then pop and compare.
   task automatic applyStimulus(input string tag, input logic [1:0] ren,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic clr);
      logic       wr_ok;
      logic [4:0] ad [2];
      exp_t       e;
      @(negedge clk);
      bus32.rd_en_in   = ren;
      bus32.rd_addr_in = {a1, a0};
      bus32.wr_en_in   = we;
      bus32.wr_addr_in = wa;
      bus32.wr_data_in = wd;
      bus32.clr_req_in = clr;
      ad[0] = a0;
      ad[1] = a1;
      wr_ok = we && !mdl_busy && (wa != 5'd0);
      for (int k = 0; k < 2; k++) begin
         if (ren[k]) begin
            if (ad[k] == 5'd0 || mdl_busy)         mdl_rs[k] = '0;
            else if (BYP && wr_ok && wa == ad[k])  mdl_rs[k] = wd;
            else                                   mdl_rs[k] = mdl_mem[ad[k]];
         end
      end
      if (wr_ok) mdl_mem[wa] = wd;
      if (mdl_busy) begin
         mdl_mem[mdl_cnt] = '0;
         if (mdl_cnt == 31) begin
            mdl_busy = 1'b0;
            mdl_cnt  = 0;
         end else begin
            mdl_cnt++;
         end
      end else if (clr) begin
         mdl_busy = 1'b1;
         mdl_cnt  = 1;
      end
      for (int k = 0; k < 2; k++) begin
         e.tag  = $sformatf("%s/rs%0d", tag, k);
         e.port = k;
         e.exp  = mdl_rs[k];
         sbq.push_back(e);
      end
      e.tag  = $sformatf("%s/busy", tag);
      e.port = -1;
      e.exp  = {31'b0, mdl_busy};
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (bus32.busy_out) busy_seen++;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.port < 0) checkOutput(e.tag, {31'b0, bus32.busy_out}, e.exp);
         else            checkOutput(e.tag, bus32.rs_data_out[e.port*32 +: 32], e.exp);
      end
   endtask

   task automatic drive16(input logic ren, input logic [3:0] ra, input logic we,
                          input logic [3:0] wa, input logic [31:0] wd, input logic clr);
      @(negedge clk);
      bus16.rd_en_in   = ren;
      bus16.rd_addr_in = ra;
      bus16.wr_en_in   = we;
      bus16.wr_addr_in = wa;
      bus16.wr_data_in = wd;
      bus16.clr_req_in = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt16;
      rst_n   = 1'b0;
      rst16_n = 1'b0;
      bus32.rd_en_in = '0; bus32.rd_addr_in = '0; bus32.wr_en_in = 1'b0;
      bus32.wr_addr_in = '0; bus32.wr_data_in = '0; bus32.clr_req_in = 1'b0;
      bus16.rd_en_in = '0; bus16.rd_addr_in = '0; bus16.wr_en_in = 1'b0;
      bus16.wr_addr_in = '0; bus16.wr_data_in = '0; bus16.clr_req_in = 1'b0;
      busy_seen = 0;
      modelReset();
      #12;
      checkOutput("rst/rs0", bus32.rs_data_out[31:0], 32'h0);
      checkOutput("rst/rs1", bus32.rs_data_out[63:32], 32'h0);
      checkOutput("rst/busy", {31'b0, bus32.busy_out}, 32'h0);
      @(negedge clk);
      rst_n   = 1'b1;
      rst16_n = 1'b1;

      applyStimulus("rdX5",  2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus("wrX3",  2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
      applyStimulus("rdX3",  2'b11, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus("wrX0",  2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0);
      applyStimulus("rdX0",  2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus("wrX7",  2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111, 1'b0);
      applyStimulus("byp",   2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
      applyStimulus("byp2",  2'b11, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus("hold0", 2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus("hold1", 2'b00, 5'd3, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0);
      applyStimulus("hold2", 2'b00, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus("hold3", 2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst/rs0", bus32.rs_data_out[31:0], 32'h0);
      checkOutput("arst/rs1", bus32.rs_data_out[63:32], 32'h0);
      checkOutput("arst/busy", {31'b0, bus32.busy_out}, 32'h0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("postRst", 2'b11, 5'd5, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);

      for (int i = 1; i < 32; i++)
         applyStimulus("fill", 2'b00, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0);
      applyStimulus("preClr", 2'b11, 5'd31, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0);
      busy_seen = 0;
      applyStimulus("clr", 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
      for (int b = 1; b <= 31; b++) begin
         if (b == 3)       applyStimulus("busyWr", 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'hFF, 1'b0);
         else if (b == 5)  applyStimulus("busyRd", 2'b11, 5'd30, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0);
         else if (b == 10) applyStimulus("reClr", 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
         else              applyStimulus("busy", 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
      end
      checkOutput("busyLen32", busy_seen, 32'd31);
      for (int i = 0; i < 16; i++)
         applyStimulus("postClr", 2'b11, 5'(2*i), 5'(2*i+1), 1'b0, 5'd0, 32'h0, 1'b0);

      for (int i = 1; i < 16; i++) drive16(1'b0, 4'd0, 1'b1, 4'(i), 32'h100 + 32'(i), 1'b0);
      drive16(1'b1, 4'd12, 1'b0, 4'd0, 32'h0, 1'b0);
      checkOutput("r16/x12", bus16.rs_data_out, 32'h10C);
      drive16(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1);
      cnt16 = bus16.busy_out ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         drive16(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
         if (bus16.busy_out) cnt16++;
      end
      checkOutput("r16/busy5", cnt16, 32'd5);
      #1;
      rst16_n = 1'b0;
      #1;
      checkOutput("r16/abortBusy", {31'b0, bus16.busy_out}, 32'h0);
      checkOutput("r16/abortRs", bus16.rs_data_out, 32'h0);
      @(negedge clk);
      rst16_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive16(1'b1, 4'(i), 1'b0, 4'd0, 32'h0, 1'b0);
         checkOutput($sformatf("r16/zero%0d", i), bus16.rs_data_out, 32'h0);
      end
      drive16(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1);
      cnt16 = 0;
      for (int g = 0; g < 40 && bus16.busy_out; g++) begin
         cnt16++;
         drive16(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
      end
      checkOutput("r16/busyLen", cnt16, 32'd15);
      checkOutput("r16/idleAfter", {31'b0, bus16.busy_out}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the STRV32I core family. It serves RV32I (32 regs) or RV32E (16 regs) at any XLEN with NRD registered read ports. Register x0 is hardwired to zero, and same-cycle write-to-read forwarding is selectable. A sequenced bulk-clear engine zeroes the array without a reset. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, default 32: data width.
- NREG, default 32: register count, 16 or 32 only.
- AW, default $clog2(NREG): address width, derived.
- NRD, default 2: number of read ports, 1..4.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rd_en_in  input  NRD  per-port read enable.
- rd_addr_in  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rs_data_out  output  NRD*XLEN  registered read data; port k uses bits [k*XLEN +: XLEN].
- wr_en_in  input  1  write enable.
- wr_addr_in  input  AW  write address.
- wr_data_in  input  XLEN  write data.
- clr_req_in  input  1  single-cycle request to zero the whole array.
- busy_out  output  1  high while a clear sequence is running.

## Operation
- Storage is NREG-1 physical registers (x1..x(NREG-1)); x0 is not stored.
  - A read of address 0 returns 0.
  - A write to address 0 is discarded.
- Write: when wr_en_in=1, busy_out=0 and wr_addr_in!=0, mem[wr_addr_in] is set to wr_data_in at the clock edge.
- Read port k: when rd_en_in[k]=1, the port's output register captures one of:
  - 0, if the address is 0 or busy_out=1;
  - wr_data_in, if a write to the same non-zero address is accepted in the same cycle (bypass, see Configuration);
  - otherwise mem[addr].
- When rd_en_in[k]=0, port k holds its previous value.
- Ports are independent. All NRD ports may read the same address in the same cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clr_req_in=1. The clear counter loads 1.
  - In CLEAR, mem[cnt] is set to 0 and cnt is incremented each cycle.
  - When cnt=NREG-1, that register is cleared and the FSM returns to IDLE.
  - busy_out = (state==CLEAR).
  - clr_req_in while in CLEAR is ignored (no restart).
  - Writes while busy are dropped; no error is flagged.

## Timing
- Reset values, all asynchronous on rst_in=0:
  - every mem entry = 0;
  - every rs_data_out port = 0;
  - FSM = IDLE, busy_out = 0, cnt = 0.
- Reset asserted mid-clear aborts the sequence immediately. The array still ends up zero.
- Read latency is 1 cycle: an address presented in cycle N appears on rs_data_out after edge N, stable through cycle N+1.
- Write latency: the written value is visible to a read issued in cycle N+1. With bypass it is also visible to a read issued in cycle N.
- Clear duration: busy_out rises the cycle after the edge where clr_req_in is sampled and stays high for exactly NREG-1 cycles (31 for NREG=32, 15 for NREG=16).
- Write and clr_req_in in the same IDLE cycle: the write is accepted, then the clear overwrites it.
- Out-of-range addresses (bits above log2(NREG) for NREG=16) cannot occur, since AW is derived.

## Configuration
- Macro REG_FILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding as described in Operation. The read in cycle N of address A, alongside an accepted write to A, returns the new data.
- Undefined: no forwarding. That read returns the pre-write mem[A], and the core's hazard logic must stall one cycle.
- x0 and busy handling are identical in both builds.

## Test plan
- Reset: drive rst_in=0 asynchronously mid-cycle → all rs_data_out=0 and busy_out=0 before the next edge. Reading x5 after release returns 0x00000000.
- Basic write/read, NRD=2: write x3=0xDEADBEEF, then the next cycle read port0=x3 and port1=x0 → 0xDEADBEEF and 0x00000000 one cycle later. Writing x0=0x12345678 → x0 still reads 0.
- Bypass: in the same cycle, write x7=0xA5A5A5A5 and read x7 (old value 0x11111111). With REG_FILE_BYPASS_EN → 0xA5A5A5A5. Without → 0x11111111, then 0xA5A5A5A5 on the following read.
- Hold: read x3 with rd_en_in=1, then with rd_en_in=0 write x3=0x55 → output stays at the old value until rd_en_in is reasserted.
- Clear: fill x1..x31 with index values, pulse clr_req_in → busy_out high for 31 cycles. A write of x9=0xFF during busy is dropped. A second clr_req_in at busy cycle 10 is ignored. Afterwards every register reads 0.
- Reset mid-clear with NREG=16: assert rst_in=0 at busy cycle 5 → busy_out=0 at once and all registers read 0. A new clr_req_in gives a 15-cycle busy window.
